// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ clients.
// One transfer at a time: grant, start strobe, wait (with watchdog), done pulse.
module spi_xfer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        timeout_err,
  output logic                        busy,
  output logic                        m_start,
  output logic [DATA_W-1:0]           m_txdata,
  input  logic                        m_done,
  input  logic [DATA_W-1:0]           m_rxdata
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last_idx, idx, pick_idx, cand;
  logic               pick_vld;
  logic [CNT_W-1:0]   wdog;
  logic               aborted;
  logic [NUM_REQ-1:0] gnt_q;
  logic               wdog_exp;

  assign wdog_exp = (wdog == CNT_W'(TIMEOUT - 1));

  // Search downward so the closest set bit after last_idx is the one kept.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_idx;
    cand     = last_idx;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last_idx) + off) % NUM_REQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (m_done || wdog_exp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= '0;
      idx      <= '0;
      last_idx <= IDX_W'(NUM_REQ - 1);
      m_txdata <= '0;
      rdata    <= '0;
      wdog     <= '0;
      aborted  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          gnt_q    <= NUM_REQ'(1) << pick_idx;
          idx      <= pick_idx;
          m_txdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
        end
        START: begin
          wdog    <= '0;
          aborted <= 1'b0;
        end
        // A late m_done after abort is dropped; rdata keeps the last good word.
        WAIT: begin
          if (m_done)        rdata   <= m_rxdata;
          else if (wdog_exp) aborted <= 1'b1;
          else               wdog    <= wdog + 1'b1;
        end
        DONE: begin
          last_idx <= idx;
          gnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt         = gnt_q;
    m_start     = (state == START);
    busy        = (state != IDLE);
    done        = (state == DONE) ? gnt_q : '0;
    timeout_err = (state == DONE) && aborted;
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed + randomized bench for spi_xfer_arbiter with a round-robin
// reference model and a scripted SPI master responder.
module tb_spi_xfer_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      gnt, done;
  logic [DW-1:0]     rdata, m_txdata, m_rxdata;
  logic              timeout_err, busy, m_start, m_done;

  logic [DW-1:0]     words [N];
  int                n_chk = 0;
  int                n_fail = 0;
  int                last_g;
  logic [DW-1:0]     exp_rdata;

  assign req_wdata = {words[3], words[2], words[1], words[0]};

  spi_xfer_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wdata(req_wdata), .gnt(gnt),
    .done(done), .rdata(rdata), .timeout_err(timeout_err), .busy(busy),
    .m_start(m_start), .m_txdata(m_txdata), .m_done(m_done), .m_rxdata(m_rxdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "simulation time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester after the last one served, wrapping.
  function automatic int next_grant(input int last, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mstart"}, m_start, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_txdata"}, m_txdata, 0);
  endtask

  // d = cycles after m_start that m_done is driven (0 = never, watchdog).
  // mode: 0 drop own req after done, 1 hold req, 2 drop all req.
  task automatic xfer(input int d, input logic [DW-1:0] rx, input int mode);
    int exp_i, n;
    logic [N-1:0] exp_g;
    exp_i = next_grant(last_g, req);
    exp_g = (exp_i < 0) ? '0 : N'(1) << exp_i;
    n = 0;
    while (m_start !== 1'b1 && n < 20) begin step(); n++; end
    chk("start_seen", m_start, 1);
    chk("gnt", gnt, exp_g);
    chk("txdata", m_txdata, (exp_i < 0) ? 0 : words[exp_i]);
    chk("busy_start", busy, 1);
    step();
    chk("start_one_cycle", m_start, 0);
    if (d == 0) begin
      repeat (TO - 1) step();
      chk("to_no_early_done", done, 0);
      step();
      chk("to_done", done, exp_g);
      chk("to_err", timeout_err, 1);
    end else begin
      repeat (d - 1) step();
      m_done = 1'b1; m_rxdata = rx;
      step();
      m_done = 1'b0; m_rxdata = $urandom;
      exp_rdata = rx;
      chk("done", done, exp_g);
      chk("no_terr", timeout_err, 0);
    end
    chk("rdata", rdata, exp_rdata);
    chk("gnt_in_done", gnt, exp_g);
    chk("txdata_in_done", m_txdata, (exp_i < 0) ? 0 : words[exp_i]);
    if (exp_i >= 0) last_g = exp_i;
    if (mode == 0 && exp_i >= 0) req[exp_i] = 1'b0;
    if (mode == 2) req = '0;
    step();
    chk("busy_low_after", busy, 0);
    chk("done_single_pulse", done, 0);
  endtask

  initial begin
    logic [N-1:0] add;
    int d;
    reset = 1'b1; req = '0; m_done = 1'b0; m_rxdata = '0;
    foreach (words[i]) words[i] = '0;
    last_g = N - 1; exp_rdata = '0;
    repeat (2) step();
    reset = 1'b0;
    chk_idle_outputs("reset");

    // single request, master answers 3 cycles after start
    words[0] = 16'hA569; req = 4'b0001;
    xfer(3, 16'h3425, 0);

    // realign priority to client 0, then all four hold until served
    reset = 1'b1; step(); reset = 1'b0;
    last_g = N - 1; exp_rdata = '0;
    chk_idle_outputs("reset2");
    words[0] = 16'h2563; words[1] = 16'h9B63; words[2] = 16'h6A61; words[3] = 16'hA569;
    req = 4'b1111;
    for (int i = 0; i < N; i++) xfer(1 + (i % 3), DW'($urandom), 0);

    // fairness: 0 and 2 hold continuously
    req = 4'b0101;
    xfer(2, DW'($urandom), 1);
    xfer(4, DW'($urandom), 1);
    xfer(1, DW'($urandom), 1);
    xfer(3, 16'h3425, 2);

    // watchdog: client 2 never answered, rdata must keep 3425
    words[2] = 16'hC0DE; req = 4'b0100;
    xfer(0, '0, 0);
    chk("to_rdata_kept", rdata, 16'h3425);

    // reset two cycles after m_start
    words[1] = 16'h1111; req = 4'b0010;
    d = 0;
    while (m_start !== 1'b1 && d < 20) begin step(); d++; end
    chk("rst_start_seen", m_start, 1);
    repeat (2) step();
    reset = 1'b1; req = 4'b0011; words[0] = 16'h0F0F;
    step();
    reset = 1'b0;
    chk_idle_outputs("midreset");
    last_g = N - 1; exp_rdata = '0;
    xfer(2, 16'hBEEF, 2);

    // spurious m_done while idle
    step();
    m_done = 1'b1; m_rxdata = 16'h0001;
    step();
    m_done = 1'b0;
    chk("spur_rdata", rdata, exp_rdata);
    chk("spur_done", done, 0);
    chk("spur_busy", busy, 0);

    // randomized traffic against the round-robin model
    for (int it = 0; it < 24; it++) begin
      add = N'($urandom_range(0, (1 << N) - 1)) & ~req;
      for (int i = 0; i < N; i++) if (add[i]) words[i] = DW'($urandom);
      req = req | add;
      if (req == '0) begin
        d = $urandom_range(0, N - 1);
        words[d] = DW'($urandom);
        req[d] = 1'b1;
      end
      d = $urandom_range(0, 6);
      xfer(d, DW'($urandom), 0);
    end
    req = '0;
    step();
    chk("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
